// File: rtl/micro_uaz_pkg.sv
// Shared definitions for the MicroUAZ clocked core: opcodes, FSM states,
// flag bit positions and small decode helpers.
package micro_uaz_pkg;

    // Opcode field values (top 4 bits of the instruction word)
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_CMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Core sequencing states
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // Bit positions inside the {N,C,Z} flag vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    // Arithmetic/logic opcodes plus CMP refresh all three flags
    function automatic logic op_sets_flags(input logic [3:0] op);
        return ((op >= OP_ADD) && (op <= OP_SHL)) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/micro_uaz_alu.sv
// Combinational ALU. Computes one extra MSB so the carry/borrow/shift-out
// bit falls out of the same wide result for every operation.
module micro_uaz_alu
    import micro_uaz_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [3:0]        i_op,
    output logic [DATA_W-1:0] o_result,
    output logic [2:0]        o_flags
);

    logic [DATA_W:0] w_wide;

    // Wide result: bit DATA_W is carry (ADD), borrow (SUB/CMP) or old MSB (SHL)
    always_comb begin
        w_wide = {1'b0, i_a};
        case (i_op)
            OP_MOV:         w_wide = {1'b0, i_b};
            OP_ADD:         w_wide = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB, OP_CMP: w_wide = {1'b0, i_a} - {1'b0, i_b};
            OP_AND:         w_wide = {1'b0, i_a & i_b};
            OP_OR:          w_wide = {1'b0, i_a | i_b};
            OP_XOR:         w_wide = {1'b0, i_a ^ i_b};
            OP_SHL:         w_wide = {i_a, 1'b0};
            default:        w_wide = {1'b0, i_a};
        endcase
    end

    // Flag packing from the wide result
    always_comb begin
        o_result        = w_wide[DATA_W-1:0];
        o_flags         = '0;
        o_flags[FLAG_Z] = (w_wide[DATA_W-1:0] == '0);
        o_flags[FLAG_C] = w_wide[DATA_W];
        o_flags[FLAG_N] = w_wide[DATA_W-1];
    end

endmodule

// File: rtl/micro_uaz_core.sv
// MicroUAZ clocked core: PC, instruction register, register file and a
// FETCH/EXEC/MEM/HALT sequencer with a req/ack data bus that tolerates
// any number of wait states.
module micro_uaz_core
    import micro_uaz_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 4,
    parameter  int PC_W     = 8,
    localparam int RSEL_W   = $clog2(NUM_REGS),
    localparam int INSTR_W  = 4 + 2*RSEL_W + DATA_W
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic [INSTR_W-1:0] i_Instruction,
    output logic [PC_W-1:0]    o_Addres_Instruction_Bus,
    input  logic [DATA_W-1:0]  i_Dato_Bus,
    output logic [DATA_W-1:0]  o_DataOut_Bus,
    output logic [DATA_W-1:0]  o_Addres_Data_Bus,
    output logic               o_RW,
    output logic               o_Data_Req,
    input  logic               i_Data_Ack,
    output logic [2:0]         o_Flags,
    output logic               o_Halted
);

    // Architectural state
    state_t             r_state;
    state_t             w_state_next;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [DATA_W-1:0]  r_regs [NUM_REGS];
    logic [2:0]         r_flags;

    // Registered bus outputs
    logic               r_req;
    logic               r_rw;
    logic [DATA_W-1:0]  r_dout;
    logic [DATA_W-1:0]  r_daddr;

    // Instruction fields, MSB first: op, rx, ry, imm
    logic [3:0]         w_op;
    logic [RSEL_W-1:0]  w_rx;
    logic [RSEL_W-1:0]  w_ry;
    logic [DATA_W-1:0]  w_imm;
    logic [DATA_W-1:0]  w_rx_val;
    logic [DATA_W-1:0]  w_ry_val;

    assign w_op     = r_ir[INSTR_W-1 -: 4];
    assign w_rx     = r_ir[DATA_W+2*RSEL_W-1 -: RSEL_W];
    assign w_ry     = r_ir[DATA_W+RSEL_W-1 -: RSEL_W];
    assign w_imm    = r_ir[DATA_W-1:0];
    assign w_rx_val = r_regs[w_rx];
    assign w_ry_val = r_regs[w_ry];

    // ALU
    logic [DATA_W-1:0]  w_alu_result;
    logic [2:0]         w_alu_flags;

    micro_uaz_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a      (w_rx_val),
        .i_b      (w_ry_val),
        .i_op     (w_op),
        .o_result (w_alu_result),
        .o_flags  (w_alu_flags)
    );

    // PC candidates; jump targets take the low PC_W bits of imm
    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_jmp_target;

    assign w_pc_inc     = r_pc + PC_W'(1);
    assign w_jmp_target = PC_W'(w_imm);

    // Control strobes produced by the output decode
    logic               w_ir_load;
    logic               w_pc_load;
    logic [PC_W-1:0]    w_pc_next;
    logic               w_reg_we;
    logic [DATA_W-1:0]  w_reg_wdata;
    logic               w_flags_we;
    logic               w_bus_start;
    logic               w_bus_done;
    logic [NUM_REGS-1:0] w_reg_sel;

    // Per-register write enables: only rx is ever written
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_sel
            assign w_reg_sel[gi] = w_reg_we && (w_rx == RSEL_W'(gi));
        end
    endgenerate

    // FSM state register
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: w_state_next = S_EXEC;
            S_EXEC: begin
                if ((w_op == OP_LD) || (w_op == OP_ST)) begin
                    w_state_next = S_MEM;
                end else if (w_op == OP_HALT) begin
                    w_state_next = S_HALT;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_MEM:   w_state_next = i_Data_Ack ? S_FETCH : S_MEM;
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_FETCH;
        endcase
    end

    // FSM output decode: datapath strobes for the current state and opcode
    always_comb begin
        w_ir_load   = 1'b0;
        w_pc_load   = 1'b0;
        w_pc_next   = w_pc_inc;
        w_reg_we    = 1'b0;
        w_reg_wdata = w_alu_result;
        w_flags_we  = 1'b0;
        w_bus_start = 1'b0;
        w_bus_done  = 1'b0;
        o_Halted    = (r_state == S_HALT);
        case (r_state)
            S_FETCH: w_ir_load = 1'b1;
            S_EXEC: begin
                w_flags_we = op_sets_flags(w_op);
                case (w_op)
                    OP_NOP, OP_CMP: w_pc_load = 1'b1;
                    OP_LDI: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = w_imm;
                        w_pc_load   = 1'b1;
                    end
                    OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
                        w_reg_we  = 1'b1;
                        w_pc_load = 1'b1;
                    end
                    OP_LD, OP_ST: w_bus_start = 1'b1;
                    OP_JMP: begin
                        w_pc_load = 1'b1;
                        w_pc_next = w_jmp_target;
                    end
                    // Branches see the flags left by earlier instructions
                    OP_JZ: begin
                        w_pc_load = 1'b1;
                        w_pc_next = r_flags[FLAG_Z] ? w_jmp_target : w_pc_inc;
                    end
                    OP_JC: begin
                        w_pc_load = 1'b1;
                        w_pc_next = r_flags[FLAG_C] ? w_jmp_target : w_pc_inc;
                    end
                    OP_HALT: w_pc_load = 1'b0;
                    default: w_pc_load = 1'b1;
                endcase
            end
            S_MEM: begin
                if (i_Data_Ack) begin
                    w_bus_done  = 1'b1;
                    w_pc_load   = 1'b1;
                    w_reg_we    = (w_op == OP_LD);
                    w_reg_wdata = i_Dato_Bus;
                end
            end
            default: w_ir_load = 1'b0;
        endcase
    end

    // Instruction register and program counter
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_ir <= '0;
            r_pc <= '0;
        end else begin
            if (w_ir_load) r_ir <= i_Instruction;
            if (w_pc_load) r_pc <= w_pc_next;
        end
    end

    // Register file and flags
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_flags <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_reg_sel[i]) r_regs[i] <= w_reg_wdata;
            end
            if (w_flags_we) r_flags <= w_alu_flags;
        end
    end

    // Bus interface: captured on MEM entry, held until the acknowledging edge
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_req   <= 1'b0;
            r_rw    <= 1'b0;
            r_dout  <= '0;
            r_daddr <= '0;
        end else if (w_bus_start) begin
            r_req   <= 1'b1;
            r_rw    <= (w_op == OP_ST);
            r_daddr <= w_ry_val;
            if (w_op == OP_ST) r_dout <= w_rx_val;
        end else if (w_bus_done) begin
            r_req <= 1'b0;
            r_rw  <= 1'b0;
        end
    end

    assign o_Addres_Instruction_Bus = r_pc;
    assign o_DataOut_Bus            = r_dout;
    assign o_Addres_Data_Bus        = r_daddr;
    assign o_RW                     = r_rw;
    assign o_Data_Req               = r_req;
    assign o_Flags                  = r_flags;

endmodule

// File: doc/micro_uaz_core.md
Name: micro_uaz_core

Overview:
- Clocked, parametrised 8-bit-class microcontroller core; successor to the team's combinational MicroUAZ datapath.
- Adds a program counter, an instruction register and a multi-cycle FSM (fetch / execute / memory).
- Adds a req/ack handshake on the data bus with unlimited wait states, plus conditional branches and halt.
- Sits between the instruction ROM and the data memory/peripheral bus at the top of the micro subsystem.

Parameters:
- DATA_W, 8: datapath, register and data-address width.
- NUM_REGS, 4: general registers; power of 2, ≥2. RSEL_W = log2(NUM_REGS).
- PC_W, 8: instruction address width.
- INSTR_W, 4+2*RSEL_W+DATA_W: derived, not overridable. Fields are [op 4][rx RSEL_W][ry RSEL_W][imm DATA_W], MSB first.

Ports:
- i_Clk  in  1  single clock; all state on the rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Instruction  in  INSTR_W  ROM data; combinational from o_Addres_Instruction_Bus.
- o_Addres_Instruction_Bus  out  PC_W  current PC.
- i_Dato_Bus  in  DATA_W  read data; valid when i_Data_Ack=1.
- o_DataOut_Bus  out  DATA_W  write data.
- o_Addres_Data_Bus  out  DATA_W  data address.
- o_RW  out  1  1 = write, 0 = read; meaningful only while o_Data_Req=1.
- o_Data_Req  out  1  bus request.
- i_Data_Ack  in  1  bus completion.
- o_Flags  out  3  {N,C,Z}.
- o_Halted  out  1  core is in HALT.

Behaviour:
- Reset, asynchronous, any state including mid-handshake:
  - PC=0, IR=0, all registers=0, flags=0, state=FETCH.
  - o_Data_Req=0, o_RW=0, o_DataOut_Bus=0, o_Addres_Data_Bus=0, o_Halted=0.
  - An outstanding bus access is abandoned.
- States:
  - FETCH: IR <= i_Instruction at the clock edge; go to EXEC.
  - EXEC: decode IR and act.
    - LD/ST go to MEM.
    - HALT goes to HALT.
    - All other opcodes complete here and go to FETCH.
  - MEM: see handshake below.
  - HALT: terminal until reset.
- Opcodes (rx/ry are register indices; imm is DATA_W bits):
  - 0 NOP.
  - 1 LDI: rx=imm.
  - 2 MOV: rx=ry.
  - 3 ADD: rx=rx+ry.
  - 4 SUB: rx=rx-ry.
  - 5 AND; 6 OR; 7 XOR.
  - 8 SHL: rx=rx<<1.
  - 9 LD: rx=mem[ry].
  - A ST: mem[ry]=rx.
  - B JMP imm.
  - C JZ imm.
  - D JC imm.
  - E CMP: flags from rx-ry, no register write.
  - F HALT.
- Arithmetic (all modulo 2^DATA_W):
  - ADD: C = carry out.
  - SUB/CMP: C = borrow, i.e. rx<ry unsigned.
  - SHL: C = old rx MSB.
  - Z = (result==0); N = result MSB.
  - Opcodes 3–8 and E update all three flags. Others leave flags unchanged.
- PC:
  - PC+1 on completion of any non-jump; wraps 2^PC_W-1 → 0.
  - JMP, or JZ/JC with the flag set: PC = imm[PC_W-1:0].
  - JZ/JC with the flag clear: PC+1.
  - Branches test flags as they stood before EXEC.
- Latency: 2 cycles per non-memory instruction; memory instructions take 3 + wait cycles.
- MEM handshake:
  - On entry, drive o_Data_Req=1, o_Addres_Data_Bus=reg[ry]; for ST also o_RW=1, o_DataOut_Bus=reg[rx].
  - Address, data and RW are held stable while Req=1.
  - On a clock edge with i_Data_Ack=1: LD writes i_Dato_Bus to rx, PC+1, Req deasserts, state goes to FETCH.
  - Ack already high on the first MEM cycle completes in that cycle.
  - Ack outside MEM is ignored.
- o_Data_Req is registered and goes low in the cycle after Ack.
- Outside MEM, bus outputs hold their last value; Req=0, RW=0.
- o_Halted=1 in HALT. PC then holds the HALT address plus nothing, i.e. the PC is not incremented.
- rx==ry is legal for all opcodes. ST/LD with rx==ry use the pre-instruction value.

Decomposition:
- Package micro_uaz_pkg:
  - opcode localparams OP_NOP..OP_HALT;
  - state encoding S_FETCH/S_EXEC/S_MEM/S_HALT;
  - flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_N=2.
- One combinational sub-module, micro_uaz_alu (DATA_W param): inputs a, b, op; outputs result and {N,C,Z}.
- Register file and FSM are inline in micro_uaz_core.

Test Plan:
- Reset/fetch: release reset with ROM[0]=LDI r1,0x5A and ROM[1]=HALT.
  - Expect r1=0x5A; PC=1; o_Halted=1 at cycle 4.
  - Flags remain 0.
- ALU flags: LDI r0,0xF0; LDI r1,0x20; ADD r0,r1.
  - Expect r0=0x10, C=1, Z=0, N=0.
  - Then SUB r1,r1: r1=0, Z=1, C=0.
- Branches: CMP r2,r3 with r2=3, r3=5 (C=1); JC 0x40.
  - Expect PC=0x40.
  - JZ 0x10 with Z=0: expect PC advances to 0x41.
- Memory wait states: ST r1→[r0] with r0=0x80, r1=0x33; hold Ack low for 3 cycles.
  - Expect Req=1, RW=1, addr 0x80, data 0x33, all stable for 4 cycles.
  - LD r2 with Ack+data 0xC7 on the first MEM cycle: expect r2=0xC7.
- Async reset mid-MEM: assert i_Rst_n=0 during a pending LD.
  - Expect Req=0 immediately, without waiting for a clock edge.
  - On release, fetch resumes from PC=0 with all registers 0.
- PC wrap: place NOP at 0xFF.
  - Expect the next fetch address to be 0x00.
